// File: rtl/seq_divider.sv
// Multicycle restoring integer divider: one quotient bit per clock, signed or
// unsigned per operation, remainder in hi and quotient in lo.
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] raw_q, raw_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Working partial remainder is WIDTH+1 bits so the trial subtraction sign
  // can be read directly from the top bit.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    shifted = {rem_q, dvd_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};

    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    raw_d   = raw_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d   = magnitude(dividend, is_signed);
          dvs_d   = magnitude(divisor, is_signed);
          raw_d   = dividend;
          neg_q_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_r_d = is_signed & dividend[WIDTH-1];
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = CW'(WIDTH);
          busy_d  = 1'b1;
          zero_d  = (divisor == '0);
          state_d = (divisor == '0) ? S_FIX : S_ITER;
        end
      end
      S_ITER: begin
        dvd_d = dvd_q << 1;
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (zero_q) begin
          hi_d = raw_q;
          lo_d = '1;
          dz_d = 1'b1;
        end else begin
          hi_d = apply_sign(rem_q, neg_r_q);
          lo_d = apply_sign(quo_q, neg_q_q);
          dz_d = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      raw_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      raw_q   <= raw_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider at WIDTH=32 and WIDTH=8 with a plain
// arithmetic reference model and per-cycle busy/done/latency monitoring.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start32, start8;
  logic        sgn;
  logic [31:0] a, b;
  logic        busy32, done32, dz32;
  logic [31:0] hi32, lo32;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          st;
    int          due;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];

  seq_divider #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .is_signed(sgn),
    .dividend(a), .divisor(b), .busy(busy32), .done(done32),
    .div_zero(dz32), .hi(hi32), .lo(lo32)
  );

  seq_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .is_signed(sgn),
    .dividend(a[7:0]), .divisor(b[7:0]), .busy(busy8), .done(done8),
    .div_zero(dz8), .hi(hi8), .lo(lo8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference: truncating division on w-bit values widened to 64 bits.
  function automatic void model(input int w, input bit s, input logic [31:0] x,
                                input logic [31:0] y, output logic [31:0] q,
                                output logic [31:0] r, output logic dz);
    longint m, sx, sy, lq, lr;
    m  = (longint'(1) << w) - 1;
    sx = longint'(x) & m;
    sy = longint'(y) & m;
    if (sy == 0) begin
      dz = 1'b1;
      q  = 32'(m);
      r  = 32'(sx);
      return;
    end
    dz = 1'b0;
    if (s) begin
      if (sx[w-1]) sx = sx - (longint'(1) << w);
      if (sy[w-1]) sy = sy - (longint'(1) << w);
    end
    lq = sx / sy;
    lr = sx % sy;
    q  = 32'(lq & m);
    r  = 32'(lr & m);
  endfunction

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      logic exp_busy;
      exp_t e;
      exp_busy = (q32.size() > 0 && cyc >= q32[0].st && cyc < q32[0].due);
      chk("busy32", {31'b0, busy32}, {31'b0, exp_busy});
      if (done32) begin
        if (q32.size() == 0) chk("spurious_done32", 32'd1, 32'd0);
        else begin
          e = q32.pop_front();
          chk("latency32", cyc, e.due);
          chk("lo32", lo32, e.q);
          chk("hi32", hi32, e.r);
          chk("dz32", {31'b0, dz32}, {31'b0, e.dz});
        end
      end else if (q32.size() > 0 && cyc >= q32[0].due) begin
        chk("timeout32", cyc, q32[0].due - 1);
        void'(q32.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      logic exp_busy;
      exp_t e;
      exp_busy = (q8.size() > 0 && cyc >= q8[0].st && cyc < q8[0].due);
      chk("busy8", {31'b0, busy8}, {31'b0, exp_busy});
      if (done8) begin
        if (q8.size() == 0) chk("spurious_done8", 32'd1, 32'd0);
        else begin
          e = q8.pop_front();
          chk("latency8", cyc, e.due);
          chk("lo8", {24'b0, lo8}, e.q);
          chk("hi8", {24'b0, hi8}, e.r);
          chk("dz8", {31'b0, dz8}, {31'b0, e.dz});
        end
      end else if (q8.size() > 0 && cyc >= q8[0].due) begin
        chk("timeout8", cyc, q8[0].due - 1);
        void'(q8.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a start for one DUT and push the expected outcome.
  task automatic launch(input int w, input bit s, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    sgn = s;
    a   = x;
    b   = y;
    model(w, s, x, y, e.q, e.r, e.dz);
    e.st  = cyc + 1;
    e.due = cyc + 1 + (e.dz ? 1 : w + 1);
    if (w == 32) begin start32 = 1'b1; q32.push_back(e); end
    else begin start8 = 1'b1; q8.push_back(e); end
  endtask

  task automatic wait_idle(input int w);
    for (int i = 0; i < 100; i++) begin
      if ((w == 32 ? q32.size() : q8.size()) == 0) break;
      step();
    end
    step();
  endtask

  task automatic run(input int w, input bit s, input logic [31:0] x, input logic [31:0] y);
    step();
    launch(w, s, x, y);
    step();
    start32 = 1'b0;
    start8  = 1'b0;
    wait_idle(w);
  endtask

  task automatic pair(input int w, input bit s1, input logic [31:0] x1, input logic [31:0] y1,
                      input bit s2, input logic [31:0] x2, input logic [31:0] y2);
    int due;
    step();
    launch(w, s1, x1, y1);
    due = (w == 32) ? q32[q32.size()-1].due : q8[q8.size()-1].due;
    step();
    start32 = 1'b0;
    start8  = 1'b0;
    for (int i = 0; i < 100 && cyc < due; i++) step();
    launch(w, s2, x2, y2);
    step();
    start32 = 1'b0;
    start8  = 1'b0;
    wait_idle(w);
  endtask

  initial begin
    logic [31:0] x, y;
    bit s;
    int st;
    reset = 1'b1; start32 = 1'b0; start8 = 1'b0; sgn = 1'b0; a = '0; b = '0;
    repeat (3) step();
    chk("rst_busy32", {31'b0, busy32}, 32'd0);
    chk("rst_done32", {31'b0, done32}, 32'd0);
    chk("rst_dz32", {31'b0, dz32}, 32'd0);
    chk("rst_hi32", hi32, 32'd0);
    chk("rst_lo32", lo32, 32'd0);
    chk("rst_busy8", {31'b0, busy8}, 32'd0);
    chk("rst_lo8", {24'b0, lo8}, 32'd0);
    reset = 1'b0;

    run(32, 1'b0, 32'd100, 32'd7);
    run(32, 1'b1, -32'sd100, 32'd7);
    run(32, 1'b1, 32'd100, -32'sd7);
    run(32, 1'b1, -32'sd100, -32'sd7);
    run(32, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run(32, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    run(32, 1'b0, 32'd55, 32'd0);
    run(32, 1'b0, 32'd9, 32'd3);
    run(8, 1'b0, 32'd200, 32'd13);
    run(8, 1'b1, 32'h80, 32'hFF);
    run(8, 1'b1, 32'h9C, 32'd0);

    // Start re-asserted mid-operation must be ignored.
    step();
    launch(32, 1'b0, 32'd1000, 32'd10);
    step();
    start32 = 1'b0;
    repeat (4) step();
    start32 = 1'b1; a = 32'd7; b = 32'd1;
    step();
    start32 = 1'b0;
    wait_idle(32);

    pair(32, 1'b0, 32'd12345, 32'd67, 1'b1, -32'sd999, 32'd10);
    pair(8, 1'b0, 32'd250, 32'd0, 1'b1, 32'hF0, 32'h03);

    // Reset during iteration 10 aborts without a done pulse.
    step();
    launch(32, 1'b0, 32'd1000, 32'd3);
    st = cyc + 1;
    step();
    start32 = 1'b0;
    for (int i = 0; i < 100 && cyc < st + 9; i++) step();
    reset = 1'b1;
    q32.delete();
    step();
    chk("abort_busy", {31'b0, busy32}, 32'd0);
    chk("abort_done", {31'b0, done32}, 32'd0);
    chk("abort_hi", hi32, 32'd0);
    chk("abort_lo", lo32, 32'd0);
    reset = 1'b0;
    step();
    run(32, 1'b1, -32'sd77, 32'd5);

    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom);
      x = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: y = 32'($urandom_range(1, 15));
        2: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        default: y = $urandom >> $urandom_range(0, 31);
      endcase
      if (i % 5 == 4) pair(32, s, x, y, ~s, $urandom, $urandom_range(1, 1000));
      else run(32, s, x, y);
      s = 1'($urandom);
      x = $urandom;
      y = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (i % 4 == 3) pair(8, s, x, y, s, $urandom, $urandom);
      else run(8, s, x, y);
    end

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Parametrised multicycle integer divider for the multicycle datapath, replacing the fixed 32-bit signed-only divider.
- Computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor using restoring division, one quotient bit per clock.
- Supports a signed or unsigned mode per operation, a start/busy/done handshake and divide-by-zero detection.
- Results land in hi (remainder) and lo (quotient), matching the MIPS HI/LO convention used by the control unit.

Parameters:
- WIDTH, 32, operand and result width in bits; must be at least 2.
- CW, $clog2(WIDTH+1), width of the internal iteration counter (derived, do not override).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a division; sampled only while idle.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- dividend  in  WIDTH  numerator; sampled with start.
- divisor  in  WIDTH  denominator; sampled with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  single-cycle pulse when hi/lo/div_zero are updated.
- div_zero  out  1  set with done if the divisor was 0; holds until the next done.
- hi  out  WIDTH  remainder; holds until the next done.
- lo  out  WIDTH  quotient; holds until the next done.

Behaviour:
- Reset (synchronous, priority over everything):
  - busy=0, done=0, div_zero=0, hi=0, lo=0.
  - FSM goes to IDLE and all internal registers clear.
  - Reset in mid-operation aborts with no done pulse.
- FSM states: IDLE, ITER, FIX.
- IDLE:
  - On an edge with start=1, latch the operands and mode.
  - Compute magnitudes: if is_signed, take the absolute value of each operand; otherwise use the raw values.
  - Record neg_q = is_signed & (dividend sign ^ divisor sign).
  - Record neg_r = is_signed & dividend sign.
  - Clear the partial remainder (WIDTH+1 bits) and the quotient register; load counter=WIDTH; set busy=1.
  - If divisor==0, go to FIX with a zero flag; otherwise go to ITER.
- ITER, once per edge:
  - Shift {remainder, dividend magnitude} left by one.
  - Trial-subtract the divisor magnitude. If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - Decrement the counter; on the edge where the counter reaches 0, go to FIX.
- FIX, one edge:
  - lo = neg_q ? -quotient : quotient.
  - hi = neg_r ? -remainder : remainder.
  - Pulse done=1 for exactly one cycle, set busy=0, return to IDLE.
- Divide by zero:
  - FIX writes hi=dividend (raw) and lo={WIDTH{1}}, with div_zero=1.
  - Latency is 2 edges (start edge plus FIX edge).
- Latency:
  - Normal operation: done is visible after edge WIDTH+1 counted from the start-sampling edge (edge 0).
  - That is WIDTH+2 edges in total; for WIDTH=32, done appears 33 edges after the start edge.
- Rounding: truncation toward zero; the remainder takes the sign of the dividend (|rem| < |divisor|).
- Signed overflow (MIN / -1):
  - Magnitude arithmetic in WIDTH+1 bits, negate-and-truncate.
  - Result: lo = MIN, hi = 0, div_zero = 0.
- Handshake rules:
  - start while busy is ignored, and the operand inputs are don't-care during busy.
  - start is accepted on the edge immediately after the done cycle, since the block is IDLE during the done cycle.
  - A start in the same cycle as done is accepted, giving back-to-back operations.
  - div_zero clears on the next done that has a nonzero divisor.
- hi/lo/div_zero never change except at FIX or reset.

Test Plan:
- Unsigned, WIDTH=32: dividend=100, divisor=7, is_signed=0 -> done exactly 33 edges after the start edge; lo=14, hi=2, div_zero=0; busy high throughout.
- Signed signs: -100/7 -> lo=-14 (0xFFFFFFF2), hi=-2; 100/-7 -> lo=-14, hi=2; -100/-7 -> lo=14, hi=-2.
- Edge values:
  - 0x80000000 / 0xFFFFFFFF signed -> lo=0x80000000, hi=0.
  - Same operands unsigned -> lo=0, hi=0x80000000.
- Divide by zero: 55/0 -> done 2 edges after start; div_zero=1, hi=55, lo=0xFFFFFFFF. A following 9/3 -> lo=3, hi=0, div_zero=0.
- Handshake: re-assert start with new operands at cycle 5 of a busy operation -> ignored, first result intact. Start in the done cycle -> second result correct, no idle gap.
- Reset and parameter:
  - reset at iteration 10 -> next cycle busy=0, hi=lo=0, no done pulse; a new operation then completes correctly.
  - Rerun with WIDTH=8: 200/13 unsigned -> lo=15, hi=5, done 9 edges after start.
